regfile_wr_arbiter: RTL and testbench

//  Shares the single write port (rw/wdat/wren) of regfileparam between two requesters.

---
 rtl/regfile_wr_arbiter.sv | 66 ++++++
 tb/tb_regfile_wr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin sharing of the register-file write port, with a zero-fill sweep after reset
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   req0/rw0/wdat0    requester 0 write request, address and data
//   req1/rw1/wdat1    requester 1 write request, address and data
//   gnt0, gnt1        combinational grants; a high grant at an edge accepts that requester
//   rw, wdat, wren    registered write port driven into the register file
//   busy              high while the post-reset clear sweep is running
module regfile_wr_arbiter #(
  parameter int BITSIZE = 16,
  parameter int ADDSIZE = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [ADDSIZE-1:0] rw0,
  input  logic [BITSIZE-1:0] wdat0,
  input  logic               req1,
  input  logic [ADDSIZE-1:0] rw1,
  input  logic [BITSIZE-1:0] wdat1,
  output logic               gnt0,
  output logic               gnt1,
  output logic [ADDSIZE-1:0] rw,
  output logic [BITSIZE-1:0] wdat,
  output logic               wren,
  output logic               busy
);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDSIZE-1:0] cnt;
  logic last;
  logic run;
  // last records the most recent winner; on a tie the other requester wins
  always_comb begin
    run = (state == RUN) && !rst;
    gnt0 = run && req0 && (!req1 || last);
    gnt1 = run && req1 && (!req0 || !last);
    state_nxt = (state == CLEAR && cnt == '1) ? RUN : state;
  end
  assign busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt <= '0;
      last <= 1'b1;
      rw <= '0;
      wdat <= '0;
      wren <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) begin
        cnt <= cnt + 1'b1;
        rw <= cnt;
        wdat <= '0;
        wren <= 1'b1;
      end else begin
        wren <= gnt0 || gnt1;
        if (gnt0 || gnt1) begin
          rw <= gnt0 ? rw0 : rw1;
          wdat <= gnt0 ? wdat0 : wdat1;
          last <= gnt1;
        end
      end
    end
  end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: randomized and directed checks of the write arbiter against a behavioural model
module tb_regfile_wr_arbiter;
  localparam int NREG = 16;
  logic clk = 0, rst = 1;
  logic req0 = 0, req1 = 0;
  logic [3:0] rw0 = 0, rw1 = 0, rw;
  logic [15:0] wdat0 = 0, wdat1 = 0, wdat;
  logic gnt0, gnt1, wren, busy;
  int checks = 0, passed = 0;
  logic [15:0] dut_mem [NREG];
  logic [15:0] m_mem [NREG];
  int m_idx = NREG;
  bit m_last = 1, m_wren = 0;
  logic [3:0] m_rw = 0;
  logic [15:0] m_wdat = 0;

  regfile_wr_arbiter dut (
    .clk(clk), .rst(rst), .req0(req0), .rw0(rw0), .wdat0(wdat0),
    .req1(req1), .rw1(rw1), .wdat1(wdat1), .gnt0(gnt0), .gnt1(gnt1),
    .rw(rw), .wdat(wdat), .wren(wren), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (wren === 1'b1) dut_mem[rw] <= wdat;

  function automatic bit m_busy();
    return m_idx < NREG;
  endfunction

  task automatic model_gnt(output bit g0, output bit g1);
    g0 = 0;
    g1 = 0;
    if (!rst && !m_busy()) begin
      if (req0 && req1) begin
        g0 = m_last;
        g1 = !m_last;
      end else begin
        g0 = req0;
        g1 = req1;
      end
    end
  endtask

  task automatic drive(bit r0, logic [3:0] a0, logic [15:0] d0, bit r1, logic [3:0] a1, logic [15:0] d1);
    req0 = r0; rw0 = a0; wdat0 = d0;
    req1 = r1; rw1 = a1; wdat1 = d1;
    #1;
  endtask

  task automatic tick();
    bit g0, g1;
    model_gnt(g0, g1);
    if (m_wren) m_mem[m_rw] = m_wdat;
    if (rst) begin
      m_idx = 0; m_last = 1; m_wren = 0; m_rw = 0; m_wdat = 0;
    end else if (m_busy()) begin
      m_wren = 1; m_rw = 4'(m_idx); m_wdat = 0; m_idx++;
    end else if (g0 || g1) begin
      m_wren = 1; m_rw = g0 ? rw0 : rw1; m_wdat = g0 ? wdat0 : wdat1; m_last = g1;
    end else m_wren = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 4'd1, 16'h1234, 1, 4'd2, 16'h5678);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({gnt0, gnt1} !== 2'b00) $display("FAIL reset_gnt got=%b exp=00", {gnt0, gnt1}); else passed++;
      checks++; if ({busy, wren, rw, wdat} !== {1'b1, 1'b0, 4'd0, 16'd0}) $display("FAIL reset_out got busy=%b wren=%b rw=%0d wdat=%h exp busy=1 wren=0 rw=0 wdat=0", busy, wren, rw, wdat); else passed++;
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_clear_sweep();
    int pulses = 0;
    rst = 0;
    for (int i = 0; i < NREG + 2; i++) begin
      tick();
      if (wren === 1'b1 && wdat === 16'd0 && rw === 4'(i) && i < NREG) pulses++;
      checks++; if ({wren, rw, wdat, busy} !== {m_wren, m_rw, m_wdat, m_busy()}) $display("FAIL sweep_out cyc=%0d got wren=%b rw=%0d wdat=%h busy=%b exp wren=%b rw=%0d wdat=%h busy=%b", i, wren, rw, wdat, busy, m_wren, m_rw, m_wdat, m_busy()); else passed++;
    end
    checks++; if (pulses !== NREG) $display("FAIL sweep_pulses got=%0d exp=%0d", pulses, NREG); else passed++;
    for (int a = 0; a < NREG; a++) begin
      checks++; if (dut_mem[a] !== 16'd0) $display("FAIL sweep_read addr=%0d got=%h exp=0000", a, dut_mem[a]); else passed++;
    end
  endtask

  task automatic test_round_robin();
    bit g0, g1;
    bit exp_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    drive(1, 4'd5, 16'h1111, 1, 4'd6, 16'h2222);
    for (int i = 0; i < 4; i++) begin
      model_gnt(g0, g1);
      checks++; if ({gnt0, gnt1} !== {!exp_seq[i], exp_seq[i]} || {g0, g1} !== {gnt0, gnt1}) $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", i, {gnt0, gnt1}, {!exp_seq[i], exp_seq[i]}); else passed++;
      tick();
      checks++; if ({wren, rw, wdat} !== {1'b1, exp_seq[i] ? 4'd6 : 4'd5, exp_seq[i] ? 16'h2222 : 16'h1111}) $display("FAIL rr_write cyc=%0d got wren=%b rw=%0d wdat=%h", i, wren, rw, wdat); else passed++;
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_single_write();
    drive(1, 4'd3, 16'hBEEF, 0, 4'd8, 16'h0);
    checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL single_gnt got=%b exp=10", {gnt0, gnt1}); else passed++;
    tick();
    checks++; if ({wren, rw, wdat} !== {1'b1, 4'd3, 16'hBEEF}) $display("FAIL single_write got wren=%b rw=%0d wdat=%h exp wren=1 rw=3 wdat=beef", wren, rw, wdat); else passed++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    checks++; if ({wren, rw, wdat} !== {1'b0, 4'd3, 16'hBEEF}) $display("FAIL single_hold got wren=%b rw=%0d wdat=%h exp wren=0 rw=3 wdat=beef", wren, rw, wdat); else passed++;
    checks++; if (dut_mem[3] !== 16'hBEEF) $display("FAIL single_read got=%h exp=beef", dut_mem[3]); else passed++;
  endtask

  task automatic test_back_to_back();
    drive(1, 4'd2, 16'hA5A5, 0, 0, 0);
    checks++; if ({gnt0, gnt1} !== 2'b10) $display("FAIL b2b_gnt0 got=%b exp=10", {gnt0, gnt1}); else passed++;
    tick();
    drive(0, 0, 0, 1, 4'd9, 16'h5A5A);
    checks++; if ({gnt0, gnt1} !== 2'b01) $display("FAIL b2b_gnt1 got=%b exp=01", {gnt0, gnt1}); else passed++;
    checks++; if ({wren, rw} !== {1'b1, 4'd2}) $display("FAIL b2b_first got wren=%b rw=%0d exp wren=1 rw=2", wren, rw); else passed++;
    tick();
    checks++; if ({wren, rw, wdat} !== {1'b1, 4'd9, 16'h5A5A}) $display("FAIL b2b_second got wren=%b rw=%0d wdat=%h exp wren=1 rw=9 wdat=5a5a", wren, rw, wdat); else passed++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic test_busy_request();
    bit g0, g1;
    int first = -1;
    rst = 1;
    drive(0, 0, 0, 1, 4'd12, 16'hC0DE);
    tick();
    rst = 0;
    for (int i = 0; i < NREG + 4 && first < 0; i++) begin
      model_gnt(g0, g1);
      checks++; if ({gnt0, gnt1} !== {g0, g1}) $display("FAIL busy_gnt cyc=%0d got=%b exp=%b", i, {gnt0, gnt1}, {g0, g1}); else passed++;
      if (gnt1 === 1'b1) first = i;
      tick();
      checks++; if ({wren, rw, wdat, busy} !== {m_wren, m_rw, m_wdat, m_busy()}) $display("FAIL busy_out cyc=%0d got wren=%b rw=%0d wdat=%h busy=%b", i, wren, rw, wdat, busy); else passed++;
    end
    checks++; if (first !== NREG) $display("FAIL busy_first_grant got=%0d exp=%0d", first, NREG); else passed++;
    drive(0, 0, 0, 0, 0, 0);
    tick();
    checks++; if (dut_mem[12] !== 16'hC0DE) $display("FAIL busy_read got=%h exp=c0de", dut_mem[12]); else passed++;
  endtask

  task automatic test_reset_mid_sweep();
    int pulses = 0;
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 8; i++) tick();
    checks++; if ({wren, rw} !== {1'b1, 4'd7}) $display("FAIL mid_pre got wren=%b rw=%0d exp wren=1 rw=7", wren, rw); else passed++;
    rst = 1;
    tick();
    checks++; if ({wren, rw, busy} !== {1'b0, 4'd0, 1'b1}) $display("FAIL mid_reset got wren=%b rw=%0d busy=%b exp wren=0 rw=0 busy=1", wren, rw, busy); else passed++;
    rst = 0;
    for (int i = 0; i < NREG + 1; i++) begin
      tick();
      if (wren === 1'b1) pulses++;
      checks++; if ({wren, rw, wdat, busy} !== {m_wren, m_rw, m_wdat, m_busy()}) $display("FAIL mid_out cyc=%0d got wren=%b rw=%0d busy=%b exp wren=%b rw=%0d busy=%b", i, wren, rw, busy, m_wren, m_rw, m_busy()); else passed++;
    end
    checks++; if (pulses !== NREG) $display("FAIL mid_pulses got=%0d exp=%0d", pulses, NREG); else passed++;
  endtask

  task automatic test_random();
    bit p0 = 0, p1 = 0, g0, g1;
    logic [3:0] a0 = 0, a1 = 0;
    logic [15:0] d0 = 0, d1 = 0;
    for (int i = 0; i < 300; i++) begin
      if (!p0 && $urandom_range(1, 0) == 1) begin p0 = 1; a0 = 4'($urandom); d0 = 16'($urandom); end
      if (!p1 && $urandom_range(1, 0) == 1) begin p1 = 1; a1 = 4'($urandom); d1 = 16'($urandom); end
      drive(p0, a0, d0, p1, a1, d1);
      model_gnt(g0, g1);
      checks++; if ({gnt0, gnt1} !== {g0, g1}) $display("FAIL rand_gnt cyc=%0d got=%b exp=%b", i, {gnt0, gnt1}, {g0, g1}); else passed++;
      tick();
      checks++; if ({wren, rw, wdat} !== {m_wren, m_rw, m_wdat}) $display("FAIL rand_out cyc=%0d got wren=%b rw=%0d wdat=%h exp wren=%b rw=%0d wdat=%h", i, wren, rw, wdat, m_wren, m_rw, m_wdat); else passed++;
      if (g0) p0 = 0;
      if (g1) p1 = 0;
    end
    drive(0, 0, 0, 0, 0, 0);
    tick();
    tick();
    for (int a = 0; a < NREG; a++) begin
      checks++; if (dut_mem[a] !== m_mem[a]) $display("FAIL rand_read addr=%0d got=%h exp=%h", a, dut_mem[a], m_mem[a]); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_clear_sweep();
    test_round_robin();
    test_single_write();
    test_back_to_back();
    test_busy_request();
    test_reset_mid_sweep();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
